// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst reader.
// The optional stall counter is enabled by defining RAM_BURST_READER_STALL_CNT_EN.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rbr_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive RAM words through port B and streams them out with last.
// Defining RAM_BURST_READER_STALL_CNT_EN adds a saturating back-pressure cycle counter.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    burst_len,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_we_b,
  input  logic [D_WIDTH-1:0]     ram_rdata,
  output logic                   m_valid,
  output logic [D_WIDTH-1:0]     m_data,
  output logic                   m_last,
  input  logic                   m_ready,
`ifdef RAM_BURST_READER_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output rbr_state_e             dbg_state
);

  // Stream handshake: a beat transfers on any rising edge where m_valid && m_ready;
  // m_valid, m_data and m_last are registered and hold until that transfer happens.

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  rbr_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic                    m_valid_q, m_valid_d;
  logic [D_WIDTH-1:0]      m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    load;

`ifdef RAM_BURST_READER_STALL_CNT_EN
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
`ifdef RAM_BURST_READER_STALL_CNT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
`ifdef RAM_BURST_READER_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = burst_len;
          state_d     = (burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        // The output register refills in the same cycle it drains, giving one beat per cycle.
        load = (!m_valid_q || m_ready) && (remaining_q != '0);
        if (load) begin
          m_data_d    = ram_rdata;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == REM_ONE);
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = FLUSH;
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      FLUSH: begin
        if (m_valid_q && m_ready && m_last_q) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef RAM_BURST_READER_STALL_CNT_EN
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start) begin
      stall_cnt_d = '0;
    end else if (m_valid_q && !m_ready && stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    ram_addr  = cur_addr_q;
    ram_we_b  = 1'b0;
    m_valid   = m_valid_q;
    m_data    = m_data_q;
    m_last    = m_last_q;
    dbg_state = state_q;
  end

endmodule
